// File: rtl/noc_params.sv
// Shared NoC definitions: flit format, flit labels, VC/destination widths
// and the input-port controller state encoding.
package noc_params;

    localparam int VC_SIZE          = 2;
    localparam int DEST_ADDR_SIZE_X = 4;
    localparam int DEST_ADDR_SIZE_Y = 4;
    localparam int PAYLOAD_SIZE     = 8;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VA     = 2'd1,
        ACTIVE = 2'd2
    } port_state_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     payload;
    } flit_t;

    function automatic logic is_head_label(input flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_tail_label(input flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

endpackage

// File: rtl/circular_buffer.sv
// Flit FIFO with power-of-two depth. A write into a full buffer is accepted
// only when a read happens in the same cycle, freeing the slot.
module circular_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data_i,
    input  logic  read_i,
    input  logic  write_i,
    output flit_t data_o,
    output logic  is_full_o,
    output logic  is_empty_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    flit_t            mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_read, do_write;

    assign is_empty_o = (count_q == '0);
    assign is_full_o  = (count_q == CNT_W'(BUFFER_SIZE));
    assign do_read    = read_i & ~is_empty_o;
    assign do_write   = write_i & (~is_full_o | do_read);
    assign data_o     = mem_q[rd_ptr_q];

    // Pointers are exactly log2(depth) wide, so the increment wraps for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_read)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_write) - CNT_W'(do_read);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vc_buffer_ctrl.sv
// Virtual-channel input buffer controller: packet FSM (IDLE/VA/ACTIVE),
// destination and output-VC latches, and credit/error pulse generation.
module vc_buffer_ctrl
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  flit_t                       data_i,
    input  logic                        valid_i,
    input  logic                        va_grant_i,
    input  logic [VC_SIZE-1:0]          out_vc_i,
    input  logic                        sa_grant_i,
    output flit_t                       data_o,
    output logic                        va_request_o,
    output logic                        sa_request_o,
    output logic [DEST_ADDR_SIZE_X-1:0] x_dest_o,
    output logic [DEST_ADDR_SIZE_Y-1:0] y_dest_o,
    output logic                        credit_o,
    output logic                        error_o,
    output logic                        is_full_o,
    output logic                        is_empty_o,
    output port_state_t                 state_o
);

    port_state_t                 state_q;
    logic [VC_SIZE-1:0]          out_vc_q;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest_q;
    logic                        credit_q, error_q;

    flit_t front;
    logic  front_is_head, discard, grant_pop, pop, drop;

    circular_buffer #(.BUFFER_SIZE(BUFFER_SIZE)) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .read_i    (pop),
        .write_i   (valid_i),
        .data_o    (front),
        .is_full_o (is_full_o),
        .is_empty_o(is_empty_o)
    );

    // A packet must open with a head flit; anything else at the front in IDLE is junk.
    assign front_is_head = is_head_label(front.flit_label);
    assign discard       = (state_q == IDLE) & ~is_empty_o & ~front_is_head;
    assign grant_pop     = sa_grant_i & sa_request_o;
    assign pop           = discard | grant_pop;
    assign drop          = valid_i & is_full_o & ~pop;

    assign va_request_o = (state_q == VA);
    assign sa_request_o = (state_q == ACTIVE) & ~is_empty_o;
    assign x_dest_o     = x_dest_q;
    assign y_dest_o     = y_dest_q;
    assign credit_o     = credit_q;
    assign error_o      = error_q;
    assign state_o      = state_q;

    always_comb begin
        data_o = front;
        if (front_is_head) data_o.vc_id = out_vc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            out_vc_q <= '0;
            x_dest_q <= '0;
            y_dest_q <= '0;
            credit_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            credit_q <= pop;
            error_q  <= drop | discard;
            case (state_q)
                IDLE: begin
                    if (~is_empty_o && front_is_head) begin
                        state_q  <= VA;
                        x_dest_q <= front.x_dest;
                        y_dest_q <= front.y_dest;
                    end
                end
                VA: begin
                    if (va_grant_i) begin
                        state_q  <= ACTIVE;
                        out_vc_q <= out_vc_i;
                    end
                end
                ACTIVE: begin
                    if (grant_pop && is_tail_label(front.flit_label)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_buffer_ctrl.sv
// Bench for vc_buffer_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_vc_buffer_ctrl;
    import noc_params::*;

    localparam int B = 8;
    localparam int FW = $bits(flit_t);

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    flit_t                       data_i = '0;
    logic                        valid_i = 1'b0;
    logic                        va_grant_i = 1'b0;
    logic [VC_SIZE-1:0]          out_vc_i = '0;
    logic                        sa_grant_i = 1'b0;
    flit_t                       data_o;
    logic                        va_request_o, sa_request_o;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest_o;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest_o;
    logic                        credit_o, error_o, is_full_o, is_empty_o;
    port_state_t                 state_o;

    always #5 clk = ~clk;

    vc_buffer_ctrl #(.BUFFER_SIZE(B)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .va_grant_i(va_grant_i), .out_vc_i(out_vc_i), .sa_grant_i(sa_grant_i),
        .data_o(data_o), .va_request_o(va_request_o), .sa_request_o(sa_request_o),
        .x_dest_o(x_dest_o), .y_dest_o(y_dest_o), .credit_o(credit_o),
        .error_o(error_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o),
        .state_o(state_o)
    );

    int n_checks = 0;
    int n_fail = 0;
    int credit_seen = 0;

    // Reference model: flit queue plus packet progress flags.
    logic [FW-1:0]               exp_q[$];
    bit                          m_wait_vc, m_sending;
    logic [DEST_ADDR_SIZE_X-1:0] m_x;
    logic [DEST_ADDR_SIZE_Y-1:0] m_y;
    logic [VC_SIZE-1:0]          m_vc;
    bit                          m_credit, m_error;

    typedef struct {
        logic               valid;
        flit_t              data;
        logic               va_grant;
        logic [VC_SIZE-1:0] out_vc;
        logic               sa_grant;
        logic               e_va;
        logic               e_sa;
        logic               e_credit;
        logic               e_empty;
        logic [3:0]         e_x;
        logic [3:0]         e_y;
        logic               e_chk_vc;
        logic [VC_SIZE-1:0] e_vc;
    } vec_t;

    vec_t vecs[6];

    function automatic flit_t mk(input flit_label_t l, input logic [3:0] x,
                                 input logic [3:0] y, input logic [7:0] p);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = '0;
        f.x_dest     = x;
        f.y_dest     = y;
        f.payload    = p;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        flit_t       f;
        port_state_t es;
        es = m_wait_vc ? VA : (m_sending ? ACTIVE : IDLE);
        chk("is_empty", is_empty_o, exp_q.size() == 0);
        chk("is_full", is_full_o, exp_q.size() == B);
        chk("va_request", va_request_o, m_wait_vc);
        chk("sa_request", sa_request_o, m_sending && exp_q.size() != 0);
        chk("credit", credit_o, m_credit);
        chk("error", error_o, m_error);
        chk("x_dest", x_dest_o, m_x);
        chk("y_dest", y_dest_o, m_y);
        chk("state", state_o, es);
        if (exp_q.size() != 0) begin
            f = flit_t'(exp_q[0]);
            if (f.flit_label == HEAD || f.flit_label == HEADTAIL) f.vc_id = m_vc;
            chk("data_o", data_o, f);
        end
        if (credit_o) credit_seen++;
    endtask

    task automatic model_edge(input logic v, input flit_t d, input logic vg,
                              input logic [VC_SIZE-1:0] ovc, input logic sg, input logic r);
        bit    pop, discard, drop;
        flit_t f;
        if (r) begin
            exp_q.delete();
            m_wait_vc = 0; m_sending = 0;
            m_x = '0; m_y = '0; m_vc = '0;
            m_credit = 0; m_error = 0;
            return;
        end
        pop = 0; discard = 0;
        f = (exp_q.size() != 0) ? flit_t'(exp_q[0]) : flit_t'('0);
        if (!m_wait_vc && !m_sending) begin
            if (exp_q.size() != 0) begin
                if (f.flit_label == HEAD || f.flit_label == HEADTAIL) begin
                    m_wait_vc = 1; m_x = f.x_dest; m_y = f.y_dest;
                end else begin
                    pop = 1; discard = 1;
                end
            end
        end else if (m_wait_vc) begin
            if (vg) begin
                m_wait_vc = 0; m_sending = 1; m_vc = ovc;
            end
        end else if (sg && exp_q.size() != 0) begin
            pop = 1;
            if (f.flit_label == TAIL || f.flit_label == HEADTAIL) m_sending = 0;
        end
        drop = v && exp_q.size() == B && !pop;
        if (pop) void'(exp_q.pop_front());
        if (v && !drop) exp_q.push_back(d);
        m_credit = pop;
        m_error  = drop || discard;
    endtask

    task automatic drive(input logic v, input flit_t d, input logic vg,
                         input logic [VC_SIZE-1:0] ovc, input logic sg, input logic r);
        valid_i = v; data_i = d; va_grant_i = vg; out_vc_i = ovc; sa_grant_i = sg; rst = r;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge(valid_i, data_i, va_grant_i, out_vc_i, sa_grant_i, rst);
        #1;
    endtask

    task automatic step(input logic v, input flit_t d, input logic vg,
                        input logic [VC_SIZE-1:0] ovc, input logic sg, input logic r);
        drive(v, d, vg, ovc, sg, r);
        @(negedge clk);
        check_outputs();
        advance();
    endtask

    task automatic idle_step();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_t ht, f;
        logic [1:0] lbl;

        // Reset held for five edges
        repeat (5) @(posedge clk);
        #1;
        model_edge(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Single HEADTAIL packet, cycle by cycle
        ht = mk(HEADTAIL, 4'd2, 4'd3, 8'hA5);
        vecs[0] = '{1'b1, ht,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0};
        vecs[1] = '{1'b0, '0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0};
        vecs[2] = '{1'b0, '0,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 1'b0, 2'd0};
        vecs[3] = '{1'b0, '0,  1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1, 2'd1};
        vecs[4] = '{1'b0, '0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd3, 1'b0, 2'd0};
        vecs[5] = '{1'b0, '0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b0, 2'd0};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].va_grant, vecs[i].out_vc,
                  vecs[i].sa_grant, 1'b0);
            @(negedge clk);
            chk("vec_va_request", va_request_o, vecs[i].e_va);
            chk("vec_sa_request", sa_request_o, vecs[i].e_sa);
            chk("vec_credit", credit_o, vecs[i].e_credit);
            chk("vec_is_empty", is_empty_o, vecs[i].e_empty);
            chk("vec_x_dest", x_dest_o, vecs[i].e_x);
            chk("vec_y_dest", y_dest_o, vecs[i].e_y);
            if (vecs[i].e_chk_vc) chk("vec_vc_id", data_o.vc_id, vecs[i].e_vc);
            check_outputs();
            advance();
        end

        // Fill to full with an 8-flit packet, overflow once, then drain
        step(1'b1, mk(HEAD, 4'd5, 4'd6, 8'h10), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, mk(BODY, 4'd0, 4'd0, 8'(8'h20 + i)), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, mk(TAIL, 4'd0, 4'd0, 8'h30), 1'b0, '0, 1'b0, 1'b0);
        chk("fill_full", is_full_o, 1'b1);
        step(1'b1, mk(BODY, 4'd0, 4'd0, 8'hEE), 1'b0, '0, 1'b0, 1'b0);
        chk("overflow_error", error_o, 1'b1);
        chk("overflow_full", is_full_o, 1'b1);
        step(1'b0, '0, 1'b1, 2'd2, 1'b0, 1'b0);
        credit_seen = 0;
        for (int i = 0; i < B; i++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle_step();
        chk("drain_credits", credit_seen, B);
        chk("drain_idle", state_o, IDLE);
        chk("drain_empty", is_empty_o, 1'b1);

        // Full buffer: write and grant together, then run dry mid-packet
        step(1'b1, mk(HEAD, 4'd7, 4'd1, 8'h40), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, mk(BODY, 4'd0, 4'd0, 8'(8'h50 + i)), 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b1, mk(BODY, 4'd0, 4'd0, 8'h77), 1'b0, '0, 1'b1, 1'b0);
        chk("full_hold", is_full_o, 1'b1);
        chk("full_no_error", error_o, 1'b0);
        chk("full_credit", credit_o, 1'b1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle_step();
        idle_step();
        chk("dry_active", state_o, ACTIVE);
        chk("dry_sa_request", sa_request_o, 1'b0);
        step(1'b1, mk(TAIL, 4'd0, 4'd0, 8'h7F), 1'b0, '0, 1'b0, 1'b0);
        chk("refill_sa_request", sa_request_o, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        chk("tail_idle", state_o, IDLE);
        idle_step();

        // Orphan BODY at the front in IDLE
        step(1'b1, mk(BODY, 4'd0, 4'd0, 8'h99), 1'b0, '0, 1'b0, 1'b0);
        idle_step();
        chk("discard_error", error_o, 1'b1);
        chk("discard_credit", credit_o, 1'b1);
        chk("discard_idle", state_o, IDLE);
        chk("discard_empty", is_empty_o, 1'b1);
        idle_step();

        // Reset while ACTIVE with three flits queued
        step(1'b1, mk(HEAD, 4'd3, 4'd4, 8'hA0), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, mk(BODY, 4'd0, 4'd0, 8'hA1), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, mk(BODY, 4'd0, 4'd0, 8'hA2), 1'b1, 2'd1, 1'b0, 1'b0);
        chk("pre_reset_active", state_o, ACTIVE);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("rst_idle", state_o, IDLE);
        chk("rst_empty", is_empty_o, 1'b1);
        chk("rst_va_request", va_request_o, 1'b0);
        chk("rst_sa_request", sa_request_o, 1'b0);
        chk("rst_credit", credit_o, 1'b0);
        chk("rst_x_dest", x_dest_o, 4'd0);
        idle_step();

        // Grants in IDLE with an empty buffer
        step(1'b0, '0, 1'b1, 2'd3, 1'b1, 1'b0);
        chk("stray_grant_idle", state_o, IDLE);
        chk("stray_grant_credit", credit_o, 1'b0);
        idle_step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            lbl = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) lbl = 2'd1;
            f = mk(flit_label_t'(lbl), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)));
            step(1'($urandom_range(0, 9) < 6), f, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 127) == 0));
        end
        idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
